// File: rtl/pulse_sync_arb_pkg.sv
// Shared types for the pulse synchronizer arbiter: FSM state encoding and gap timer sizing.
// Optional overflow flags are enabled with PULSE_SYNC_ARB_OVF_EN.
package pulse_sync_arb_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Gap timer holds values up to GAP-2; keep at least one bit.
  function automatic int gap_cnt_w(input int gap);
    return (gap <= 2) ? 1 : $clog2(gap);
  endfunction

endpackage

// File: rtl/pulse_sync_arb_if.sv
// Requester/issue bus between the event sources and the arbiter, plus a debug view of the FSM.
// ovf_clr_i exists only when PULSE_SYNC_ARB_OVF_EN is defined.
interface pulse_sync_arb_if
  import pulse_sync_arb_pkg::*;
#(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic             en_i;
  logic [N_REQ-1:0] req_i;
  logic             pulse_o;
  logic [ID_W-1:0]  id_o;
  logic [N_REQ-1:0] pend_o;
  logic             busy_o;
  logic [N_REQ-1:0] ovf_o;
  state_e           state_o;

  // req_i are single-cycle events with no back-pressure: every high cycle is one event.
`ifdef PULSE_SYNC_ARB_OVF_EN
  logic ovf_clr_i;

  modport master (
    output en_i, req_i, ovf_clr_i,
    input  pulse_o, id_o, pend_o, busy_o, ovf_o, state_o
  );
  modport slave (
    input  en_i, req_i, ovf_clr_i,
    output pulse_o, id_o, pend_o, busy_o, ovf_o, state_o
  );
`else
  modport master (
    output en_i, req_i,
    input  pulse_o, id_o, pend_o, busy_o, ovf_o, state_o
  );
  modport slave (
    input  en_i, req_i,
    output pulse_o, id_o, pend_o, busy_o, ovf_o, state_o
  );
`endif

endinterface

// File: rtl/pulse_sync_arb_rr_picker.sv
// Combinational masked round-robin select: first set request at or after ptr_i, wrapping.
module rr_picker #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             vld_o
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] sel;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (i >= int'(ptr_i));
    end
    masked = req_i & mask;
    // Nothing at or above the pointer means the search wraps to index 0.
    sel   = (|masked) ? masked : req_i;
    gnt_o = '0;
    idx_o = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (sel[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = ID_W'(i);
      end
    end
    vld_o = |req_i;
  end

endmodule

// File: rtl/pulse_sync_arbiter.sv
// Round-robin arbiter feeding one toggle pulse synchronizer from N_REQ event sources,
// with per-source saturating queues and enforced pulse spacing. Macro: PULSE_SYNC_ARB_OVF_EN.
module pulse_sync_arbiter
  import pulse_sync_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 6
) (
  input logic              clk_i,
  input logic              arst_i,
  pulse_sync_arb_if.slave  bus
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int GW   = gap_cnt_w(GAP);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [GW-1:0]    GAP_LOAD = GW'(GAP - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] gnt_oh;
  logic [N_REQ-1:0] gnt_vec;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_vld;
  logic             pulse_q, pulse_d;
  logic             grant;
  logic [GW-1:0]    gap_q, gap_d;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      pend[i] = |cnt_q[i];
    end
  end

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i (pend),
    .ptr_i (ptr_q),
    .gnt_o (gnt_oh),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign grant   = (state_q == ST_IDLE) && bus.en_i && pick_vld;
  assign gnt_vec = grant ? gnt_oh : '0;

  // A same-edge event and grant cancel; a saturated counter drops the event.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.req_i[i] && !gnt_vec[i]) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (gnt_vec[i] && !bus.req_i[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    id_d    = id_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          pulse_d = 1'b1;
          id_d    = pick_idx;
          ptr_d   = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        gap_d   = GAP_LOAD;
        state_d = (GAP == 2) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        // Leaving on 1 lands IDLE exactly GAP-1 cycles after the pulse.
        if (gap_q <= GW'(1)) state_d = ST_IDLE;
        else                 gap_d   = gap_q - GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
      pulse_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pulse_o = pulse_q;
  assign bus.id_o    = id_q;
  assign bus.pend_o  = pend;
  assign bus.busy_o  = (state_q != ST_IDLE);
  assign bus.state_o = state_q;

`ifdef PULSE_SYNC_ARB_OVF_EN
  logic [N_REQ-1:0] ovf_q, ovf_d;

  // Set has priority over clear so a drop in the clear cycle is not lost.
  always_comb begin
    ovf_d = bus.ovf_clr_i ? '0 : ovf_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (bus.req_i[i] && !gnt_vec[i] && (cnt_q[i] == CNT_MAX)) ovf_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign bus.ovf_o = ovf_q;
`else
  assign bus.ovf_o = '0;
`endif

endmodule
